// File: rtl/mips_pkg.sv
// Shared MIPS32 core constants: ALU opcodes, operand-B select encodings and
// the forwarding hit test used by the EX-side operand muxes.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] B_SEL_RT    = 2'b00;
    localparam logic [1:0] B_SEL_IMM   = 2'b01;
    localparam logic [1:0] B_SEL_SHAMT = 2'b10;
    localparam logic [1:0] B_SEL_RS    = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hardwired to zero, so a write to it never produces a forward.
    function automatic logic fwd_hit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
        return wr && (dst == src) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-EX bundle: decoded operands/control from ID, load-use hold back to ID.
interface id_ex_operand_stage_if;
    import mips_pkg::*;

    logic              valid;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic              uses_rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic              a_sel;
    logic [1:0]        b_sel;
    logic [3:0]        alu_op;
    logic [4:0]        rd_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              load_use_stall;

    modport master (
        output valid, rs_addr, rt_addr, uses_rt, rs_data, rt_data, imm, shamt,
               a_sel, b_sel, alu_op, rd_addr, reg_write, mem_read, mem_write,
        input  load_use_stall
    );

    modport slave (
        input  valid, rs_addr, rt_addr, uses_rt, rs_data, rt_data, imm, shamt,
               a_sel, b_sel, alu_op, rd_addr, reg_write, mem_read, mem_write,
        output load_use_stall
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// One source operand's bypass: EX/MEM beats MEM/WB beats the registered value.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] reg_data,
    input  logic [4:0]        src_addr,
    input  logic              exm_reg_write,
    input  logic [4:0]        exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [4:0]        mwb_rd_addr,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [DATA_W-1:0] fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (fwd_hit(exm_reg_write, exm_rd_addr, src_addr))
            fwd_data = exm_result;
        else if (fwd_hit(mwb_reg_write, mwb_rd_addr, src_addr))
            fwd_data = mwb_result;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, ALU operand selection
// and load-use hazard detection / bubble insertion.
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    id_ex_operand_stage_if.slave   id,
    input  logic                   exm_reg_write,
    input  logic [4:0]             exm_rd_addr,
    input  logic [DATA_W-1:0]      exm_result,
    input  logic                   mwb_reg_write,
    input  logic [4:0]             mwb_rd_addr,
    input  logic [DATA_W-1:0]      mwb_result,
    output logic                   ex_valid,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [3:0]             alu_op,
    output logic [DATA_W-1:0]      ex_store_data,
    output logic [4:0]             ex_rd_addr,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic [CNT_W-1:0]       bubble_count
);

    logic              vld_p1;
    logic [4:0]        rs_addr_p1, rt_addr_p1, rd_addr_p1, shamt_p1;
    logic [DATA_W-1:0] rs_data_p1, rt_data_p1, imm_p1;
    logic              a_sel_p1;
    logic [1:0]        b_sel_p1;
    logic [3:0]        alu_op_p1;
    logic              reg_write_p1, mem_read_p1, mem_write_p1;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              load_use;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign load_use = id.valid && vld_p1 && mem_read_p1 && (rd_addr_p1 != REG_ZERO) &&
                      ((rd_addr_p1 == id.rs_addr) || (id.uses_rt && (rd_addr_p1 == id.rt_addr)));
    assign id.load_use_stall = load_use;

    // ---- ID -> EX register (stage p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            rs_addr_p1   <= '0;
            rt_addr_p1   <= '0;
            rd_addr_p1   <= '0;
            shamt_p1     <= '0;
            rs_data_p1   <= '0;
            rt_data_p1   <= '0;
            imm_p1       <= '0;
            a_sel_p1     <= 1'b0;
            b_sel_p1     <= '0;
            alu_op_p1    <= '0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            bubble_cnt   <= '0;
        end else if (flush) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
        end else if (!stall) begin
            if (load_use) begin
                vld_p1       <= 1'b0;
                reg_write_p1 <= 1'b0;
                mem_read_p1  <= 1'b0;
                mem_write_p1 <= 1'b0;
                bubble_cnt   <= sat_inc(bubble_cnt);
            end else begin
                vld_p1       <= id.valid;
                rs_addr_p1   <= id.rs_addr;
                rt_addr_p1   <= id.rt_addr;
                rd_addr_p1   <= id.rd_addr;
                shamt_p1     <= id.shamt;
                rs_data_p1   <= id.rs_data;
                rt_data_p1   <= id.rt_data;
                imm_p1       <= id.imm;
                a_sel_p1     <= id.a_sel;
                b_sel_p1     <= id.b_sel;
                alu_op_p1    <= id.alu_op;
                reg_write_p1 <= id.reg_write;
                mem_read_p1  <= id.mem_read;
                mem_write_p1 <= id.mem_write;
            end
        end
    end

    // ---- EX operand forwarding and selection (combinational after p1) ----
    fwd_mux u_fwd_rs (
        .reg_data      (rs_data_p1),
        .src_addr      (rs_addr_p1),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd_addr   (mwb_rd_addr),
        .mwb_result    (mwb_result),
        .fwd_data      (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .reg_data      (rt_data_p1),
        .src_addr      (rt_addr_p1),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd_addr   (mwb_rd_addr),
        .mwb_result    (mwb_result),
        .fwd_data      (rt_fwd)
    );

    always_comb begin
        alu_b = rs_fwd;
        case (b_sel_p1)
            B_SEL_RT:    alu_b = rt_fwd;
            B_SEL_IMM:   alu_b = imm_p1;
            B_SEL_SHAMT: alu_b = {{(DATA_W-5){1'b0}}, shamt_p1};
            default:     alu_b = rs_fwd;
        endcase
    end

    assign alu_a         = a_sel_p1 ? rt_fwd : rs_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_valid      = vld_p1;
    assign alu_op        = alu_op_p1;
    assign ex_rd_addr    = rd_addr_p1;
    assign ex_reg_write  = reg_write_p1 & vld_p1;
    assign ex_mem_read   = mem_read_p1 & vld_p1;
    assign ex_mem_write  = mem_write_p1 & vld_p1;
    assign bubble_count  = bubble_cnt;

endmodule
